// File: rtl/cmos_pkg.sv
// -----------------------------------------------------------------------------
// cmos_pkg
// Shared definitions for the OV5640 DVP line-capture slice.
//   state_t            : one-hot capture state encoding
//   PAD_BYTE           : filler byte written to complete an odd-length line
//   DEF_SKIP_FRAMES    : default count of settling frames dropped after reset
//   DEF_MAX_LINE_BYTES : default per-line FIFO write limit
//   DEF_CNT_W          : default width of line-byte / line counters
// -----------------------------------------------------------------------------
package cmos_pkg;

   typedef enum logic [5:0] {
      ST_SKIP       = 6'b000001,
      ST_WAIT_FRAME = 6'b000010,
      ST_FRAME      = 6'b000100,
      ST_LINE       = 6'b001000,
      ST_LINE_DROP  = 6'b010000,
      ST_LINE_END   = 6'b100000
   } state_t;

   localparam logic [7:0] PAD_BYTE           = 8'h00;
   localparam int         DEF_SKIP_FRAMES    = 10;
   localparam int         DEF_MAX_LINE_BYTES = 4096;
   localparam int         DEF_CNT_W          = 16;

endpackage

// File: rtl/cmos_edge_sync.sv
// -----------------------------------------------------------------------------
// cmos_edge_sync
// Registers the DVP bus once and derives vsync/href edges from the registered
// copies, so every downstream decision sees one consistent sample.
//   clk, rst_n        : pixel clock, synchronous active-low reset
//   vsync_i, href_i   : raw frame sync / line valid
//   data_i            : raw pixel byte
//   vsync_d_o, href_d_o, data_d_o : registered bus
//   vsync_rise_o      : 1-cycle, registered vsync went 0->1
//   href_rise_o       : 1-cycle, registered href went 0->1
//   href_fall_o       : 1-cycle, registered href went 1->0
// -----------------------------------------------------------------------------
module cmos_edge_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync_i,
   input  logic       href_i,
   input  logic [7:0] data_i,
   output logic       vsync_d_o,
   output logic       href_d_o,
   output logic [7:0] data_d_o,
   output logic       vsync_rise_o,
   output logic       href_rise_o,
   output logic       href_fall_o
);

   logic       vsync_d;
   logic       vsync_dd;
   logic       href_d;
   logic       href_dd;
   logic [7:0] data_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_d  <= 1'b0;
         vsync_dd <= 1'b0;
         href_d   <= 1'b0;
         href_dd  <= 1'b0;
         data_d   <= '0;
      end else begin
         vsync_d  <= vsync_i;
         vsync_dd <= vsync_d;
         href_d   <= href_i;
         href_dd  <= href_d;
         data_d   <= data_i;
      end
   end

   assign vsync_d_o    = vsync_d;
   assign href_d_o     = href_d;
   assign data_d_o     = data_d;
   assign vsync_rise_o = vsync_d & ~vsync_dd;
   assign href_rise_o  = href_d & ~href_dd;
   assign href_fall_o  = ~href_d & href_dd;

endmodule

// File: rtl/cmos_line_capture.sv
// -----------------------------------------------------------------------------
// cmos_line_capture
// Camera-side capture: skips settling frames, writes accepted line bytes into
// the line FIFO and reports line width / frame height for the UDP sender.
// Entirely in the pixel-clock domain.
//   clk, rst_n     : pixel clock, synchronous active-low reset
//   cmos_vsync     : frame sync, rising edge = frame start
//   cmos_href      : line valid
//   cmos_data      : pixel byte
//   capture_en     : frame enable, sampled at vsync rise
//   fifo_ready     : FIFO holds a full line, sampled at href rise
//   fifo_wr/_data  : FIFO write strobe and byte (bus + 2 clk)
//   href_end       : 1-cycle pulse, accepted line complete
//   if_first_href  : ended line was first accepted line of its frame
//   cmos_h         : pixels (bytes/2, rounded up) of last completed line
//   cmos_v         : accepted lines in previous frame
//   frame_done     : 1-cycle pulse when cmos_v updates
//   drop_cnt       : lines dropped for fifo_ready low (saturating)
//   len_err        : 1-cycle pulse on odd or over-length line
//   dbg_state      : current capture state
// -----------------------------------------------------------------------------
module cmos_line_capture
   import cmos_pkg::*;
#(
   parameter int SKIP_FRAMES    = DEF_SKIP_FRAMES,
   parameter int MAX_LINE_BYTES = DEF_MAX_LINE_BYTES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmos_vsync,
   input  logic             cmos_href,
   input  logic [7:0]       cmos_data,
   input  logic             capture_en,
   input  logic             fifo_ready,
   output logic             fifo_wr,
   output logic [7:0]       fifo_wr_data,
   output logic             href_end,
   output logic             if_first_href,
   output logic [CNT_W-1:0] cmos_h,
   output logic [CNT_W-1:0] cmos_v,
   output logic             frame_done,
   output logic [15:0]      drop_cnt,
   output logic             len_err,
   output state_t           dbg_state
);

   localparam int               SKIP_M1   = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;
   localparam logic [CNT_W-1:0] SKIP_LAST = SKIP_M1[CNT_W-1:0];
   localparam logic [CNT_W:0]   MAX_X     = MAX_LINE_BYTES[CNT_W:0];

   // min(bc, MAX+1)/2 rounded up; an over-length line reports one pad pixel.
   function automatic logic [CNT_W-1:0] line_pixels(input logic [CNT_W-1:0] bc);
      logic [CNT_W:0] clip;
      logic [CNT_W:0] half;
      clip = ({1'b0, bc} > MAX_X) ? MAX_X + 1'b1 : {1'b0, bc};
      half = (clip + 1'b1) >> 1;
      return half[CNT_W-1:0];
   endfunction

   logic       vsync_d;
   logic       href_d;
   logic [7:0] data_d;
   logic       vsync_rise;
   logic       href_rise;
   logic       href_fall;

   cmos_edge_sync u_edge_sync (
      .clk          (clk),
      .rst_n        (rst_n),
      .vsync_i      (cmos_vsync),
      .href_i       (cmos_href),
      .data_i       (cmos_data),
      .vsync_d_o    (vsync_d),
      .href_d_o     (href_d),
      .data_d_o     (data_d),
      .vsync_rise_o (vsync_rise),
      .href_rise_o  (href_rise),
      .href_fall_o  (href_fall)
   );

   state_t           state_q;
   logic [CNT_W-1:0] skip_cnt_q;
   logic [CNT_W-1:0] byte_cnt_q;
   logic [CNT_W-1:0] line_cnt_q;
   logic             first_pend_q;
   logic             vs_pend_q;    // vsync rise seen in LINE/LINE_END, served from FRAME
   logic             end_pend_q;   // href_end deferred one cycle behind the pad write
   logic             fifo_wr_q;
   logic [7:0]       fifo_wr_data_q;
   logic             href_end_q;
   logic             if_first_q;
   logic [CNT_W-1:0] cmos_h_q;
   logic [CNT_W-1:0] cmos_v_q;
   logic             frame_done_q;
   logic [15:0]      drop_cnt_q;
   logic             len_err_q;
   logic             vs_evt;

   assign vs_evt = vsync_rise | vs_pend_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_SKIP;
         skip_cnt_q     <= '0;
         byte_cnt_q     <= '0;
         line_cnt_q     <= '0;
         first_pend_q   <= 1'b0;
         vs_pend_q      <= 1'b0;
         end_pend_q     <= 1'b0;
         fifo_wr_q      <= 1'b0;
         fifo_wr_data_q <= '0;
         href_end_q     <= 1'b0;
         if_first_q     <= 1'b0;
         cmos_h_q       <= '0;
         cmos_v_q       <= '0;
         frame_done_q   <= 1'b0;
         drop_cnt_q     <= '0;
         len_err_q      <= 1'b0;
      end else begin
         fifo_wr_q    <= 1'b0;
         href_end_q   <= 1'b0;
         frame_done_q <= 1'b0;
         len_err_q    <= 1'b0;

         // byte_cnt_q is still intact here even if a new line starts now.
         if (end_pend_q) begin
            end_pend_q   <= 1'b0;
            href_end_q   <= 1'b1;
            cmos_h_q     <= line_pixels(byte_cnt_q);
            if_first_q   <= first_pend_q;
            first_pend_q <= 1'b0;
         end

         // Frame end and the next frame's start share one cycle.
         if (vs_evt && (state_q == ST_FRAME || state_q == ST_LINE_DROP)) begin
            vs_pend_q    <= 1'b0;
            cmos_v_q     <= line_cnt_q;
            frame_done_q <= 1'b1;
            if (capture_en) begin
               state_q      <= ST_FRAME;
               line_cnt_q   <= '0;
               first_pend_q <= 1'b1;
            end else begin
               state_q <= ST_WAIT_FRAME;
            end
         end else begin
            case (state_q)
               ST_SKIP: begin
                  if (SKIP_FRAMES == 0) begin
                     state_q <= ST_WAIT_FRAME;
                  end else if (vsync_rise) begin
                     skip_cnt_q <= skip_cnt_q + 1'b1;
                     if (skip_cnt_q == SKIP_LAST) state_q <= ST_WAIT_FRAME;
                  end
               end
               ST_WAIT_FRAME: begin
                  if (vsync_rise && capture_en) begin
                     state_q      <= ST_FRAME;
                     line_cnt_q   <= '0;
                     first_pend_q <= 1'b1;
                  end
               end
               ST_FRAME: begin
                  // href during vsync high is blanking. The first byte is on
                  // data_d in the rise cycle, so it is written here.
                  if (href_rise && !vsync_d) begin
                     if (fifo_ready) begin
                        state_q        <= ST_LINE;
                        byte_cnt_q     <= {{(CNT_W-1){1'b0}}, 1'b1};
                        fifo_wr_q      <= 1'b1;
                        fifo_wr_data_q <= data_d;
                     end else begin
                        state_q <= ST_LINE_DROP;
                        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
                     end
                  end
               end
               ST_LINE: begin
                  if (vsync_rise || href_fall) begin
                     vs_pend_q <= vsync_rise;
                     state_q   <= ST_LINE_END;
                     // Even line: last data write is on the bus now, end it next cycle.
                     if (!byte_cnt_q[0]) begin
                        href_end_q   <= 1'b1;
                        cmos_h_q     <= line_pixels(byte_cnt_q);
                        if_first_q   <= first_pend_q;
                        first_pend_q <= 1'b0;
                     end
                  end else if (href_d) begin
                     if ({1'b0, byte_cnt_q} < MAX_X) begin
                        fifo_wr_q      <= 1'b1;
                        fifo_wr_data_q <= data_d;
                     end
                     if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
               end
               ST_LINE_DROP: begin
                  if (href_fall) state_q <= ST_FRAME;
               end
               ST_LINE_END: begin
                  // The 2-clk minimum href gap keeps href rises out of this
                  // cycle; a vsync rise is carried into FRAME.
                  vs_pend_q  <= vs_pend_q | vsync_rise;
                  line_cnt_q <= line_cnt_q + 1'b1;
                  state_q    <= ST_FRAME;
                  if (byte_cnt_q[0]) begin
                     fifo_wr_q      <= 1'b1;
                     fifo_wr_data_q <= PAD_BYTE;
                     len_err_q      <= 1'b1;
                     end_pend_q     <= 1'b1;
                  end
                  if ({1'b0, byte_cnt_q} > MAX_X) len_err_q <= 1'b1;
               end
               default: state_q <= ST_SKIP;
            endcase
         end
      end
   end

   assign fifo_wr       = fifo_wr_q;
   assign fifo_wr_data  = fifo_wr_data_q;
   assign href_end      = href_end_q;
   assign if_first_href = if_first_q;
   assign cmos_h        = cmos_h_q;
   assign cmos_v        = cmos_v_q;
   assign frame_done    = frame_done_q;
   assign drop_cnt      = drop_cnt_q;
   assign len_err       = len_err_q;
   assign dbg_state     = state_q;

endmodule
